// File: rtl/maxpool_window_gen_pkg.sv
// Shared definitions for the 2x2 max-pool window generator: pixel width,
// FSM state encoding and the window field order feeding pooling input1..input4.
package maxpool_window_gen_pkg;

   localparam int unsigned DATA_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_EMIT = 2'd2
   } state_e;

   localparam int unsigned WIN_N  = 4;
   localparam int unsigned WIN_TL = 0;
   localparam int unsigned WIN_TR = 1;
   localparam int unsigned WIN_BL = 2;
   localparam int unsigned WIN_BR = 3;

endpackage

// File: rtl/maxpool_window_gen_line_buf.sv
// One-row pixel buffer: single write port at col, combinational reads at col-1 and col.
module pool_line_buf #(
   parameter int unsigned DATA_W = 5,
   parameter int unsigned IMG_W  = 4,
   parameter int unsigned COL_W  = 2
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [COL_W-1:0]  col,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_prev_c,
   output logic [DATA_W-1:0] rd_cur_c
);

   logic [DATA_W-1:0] mem_q [IMG_W];
   logic [DATA_W-1:0] mem_d [IMG_W];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[col] = wr_data;
      end
   end

   // Contents are deliberately not reset; every entry is rewritten before use.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // col is always odd when the previous column is read, so col-1 never underflows.
   assign rd_prev_c = mem_q[col - COL_W'(1)];
   assign rd_cur_c  = mem_q[col];

endmodule

// File: rtl/maxpool_window_gen.sv
// Raster-order frame to non-overlapping 2x2 windows: buffers even rows, pairs them
// with odd-row pixels, and registers tl/tr/bl/br plus valid/frame_done pulses.
module maxpool_window_gen
   import maxpool_window_gen_pkg::*;
#(
   parameter int unsigned DATA_W = maxpool_window_gen_pkg::DATA_W,
   parameter int unsigned IMG_W  = 4,
   parameter int unsigned IMG_H  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              pix_valid,
   output logic [DATA_W-1:0] win_tl,
   output logic [DATA_W-1:0] win_tr,
   output logic [DATA_W-1:0] win_bl,
   output logic [DATA_W-1:0] win_br,
   output logic              win_valid,
   output logic              frame_done,
   output logic              busy
);

   localparam int unsigned COL_W = $clog2(IMG_W);
   localparam int unsigned ROW_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   state_e                          state_q, state_d;
   logic [COL_W-1:0]                col_q, col_d;
   logic [ROW_W-1:0]                row_q, row_d;
   logic [DATA_W-1:0]               bl_hold_q, bl_hold_d;
   logic [WIN_N-1:0][DATA_W-1:0]    win_q, win_d;
   logic                            win_valid_q, win_valid_d;
   logic                            frame_done_q, frame_done_d;
   logic                            busy_q, busy_d;

   logic                            lb_wr_en_c;
   logic                            accept_c;
   logic                            row_end_c;
   logic [DATA_W-1:0]               lb_prev_c;
   logic [DATA_W-1:0]               lb_cur_c;

   pool_line_buf #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W),
      .COL_W  (COL_W)
   ) u_line_buf (
      .clk       (clk),
      .wr_en     (lb_wr_en_c),
      .col       (col_q),
      .wr_data   (pix_in),
      .rd_prev_c (lb_prev_c),
      .rd_cur_c  (lb_cur_c)
   );

   // Next-state, counters and window load.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      bl_hold_d    = bl_hold_q;
      win_d        = win_q;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      lb_wr_en_c   = 1'b0;
      accept_c     = 1'b0;
      row_end_c    = (col_q == COL_LAST);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FILL;
               col_d   = '0;
               row_d   = '0;
            end
         end
         ST_FILL: begin
            if (pix_valid) begin
               accept_c   = 1'b1;
               lb_wr_en_c = 1'b1;
               if (row_end_c) begin
                  state_d = ST_EMIT;
                  row_d   = row_q + ROW_W'(1);
               end
            end
         end
         ST_EMIT: begin
            if (pix_valid) begin
               accept_c = 1'b1;
               if (!col_q[0]) begin
                  bl_hold_d = pix_in;
               end else begin
                  win_d[WIN_TL] = lb_prev_c;
                  win_d[WIN_TR] = lb_cur_c;
                  win_d[WIN_BL] = bl_hold_q;
                  win_d[WIN_BR] = pix_in;
                  win_valid_d   = 1'b1;
               end
               if (row_end_c) begin
                  if (row_q == ROW_LAST) begin
                     state_d      = ST_IDLE;
                     row_d        = '0;
                     frame_done_d = 1'b1;
                  end else begin
                     state_d = ST_FILL;
                     row_d   = row_q + ROW_W'(1);
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (accept_c) begin
         col_d = row_end_c ? '0 : col_q + COL_W'(1);
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         bl_hold_q    <= '0;
         win_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         bl_hold_q    <= bl_hold_d;
         win_q        <= win_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign win_tl     = win_q[WIN_TL];
   assign win_tr     = win_q[WIN_TR];
   assign win_bl     = win_q[WIN_BL];
   assign win_br     = win_q[WIN_BR];
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_maxpool_window_gen.sv
// Bench for maxpool_window_gen: directed and random frames against a frame-array
// model (4x4 instance) plus a 6x2 instance checked with closed-form windows.
module tb_maxpool_window_gen;

   localparam int unsigned DW   = 5;
   localparam int unsigned W    = 4;
   localparam int unsigned H    = 4;
   localparam int unsigned NPIX = W * H;
   localparam int unsigned W6   = 6;
   localparam int unsigned H6   = 2;

   logic          clk;
   logic          rst;
   logic          start, pix_valid;
   logic [DW-1:0] pix_in;
   logic [DW-1:0] win_tl, win_tr, win_bl, win_br;
   logic          win_valid, frame_done, busy;

   logic          start6, pix_valid6;
   logic [DW-1:0] pix_in6;
   logic [DW-1:0] win_tl6, win_tr6, win_bl6, win_br6;
   logic          win_valid6, frame_done6, busy6;

   int n_cmp;
   int n_fail;
   int win_seen;

   // Reference model state: pixels of the current frame by raster index.
   bit            m_active;
   int            m_k;
   logic [DW-1:0] m_px [NPIX];
   logic [DW-1:0] stim [NPIX];
   logic          e_valid, e_done, e_busy;
   logic [DW-1:0] e_tl, e_tr, e_bl, e_br;

   maxpool_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
      .win_tl(win_tl), .win_tr(win_tr), .win_bl(win_bl), .win_br(win_br),
      .win_valid(win_valid), .frame_done(frame_done), .busy(busy)
   );

   maxpool_window_gen #(.DATA_W(DW), .IMG_W(W6), .IMG_H(H6)) dut6 (
      .clk(clk), .rst(rst), .start(start6), .pix_in(pix_in6), .pix_valid(pix_valid6),
      .win_tl(win_tl6), .win_tr(win_tr6), .win_bl(win_bl6), .win_br(win_br6),
      .win_valid(win_valid6), .frame_done(frame_done6), .busy(busy6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("win_valid",  32'(win_valid),  32'(e_valid));
      check("frame_done", 32'(frame_done), 32'(e_done));
      check("busy",       32'(busy),       32'(e_busy));
      check("win_tl",     32'(win_tl),     32'(e_tl));
      check("win_tr",     32'(win_tr),     32'(e_tr));
      check("win_bl",     32'(win_bl),     32'(e_bl));
      check("win_br",     32'(win_br),     32'(e_br));
      if (win_valid) win_seen++;
   endtask

   // Window (r-1,c-1)..(r,c) completes when the pixel at odd row r, odd col c arrives.
   task automatic model_step(input logic s, input logic v, input logic [DW-1:0] p);
      int r, c;
      e_valid = 1'b0;
      e_done  = 1'b0;
      if (!m_active) begin
         if (s) begin
            m_active = 1'b1;
            m_k      = 0;
         end
      end else if (v) begin
         m_px[m_k] = p;
         r = m_k / W;
         c = m_k % W;
         if ((r % 2 == 1) && (c % 2 == 1)) begin
            e_valid = 1'b1;
            e_tl    = m_px[(r - 1) * W + c - 1];
            e_tr    = m_px[(r - 1) * W + c];
            e_bl    = m_px[r * W + c - 1];
            e_br    = p;
         end
         if (m_k == NPIX - 1) begin
            e_done   = 1'b1;
            m_active = 1'b0;
         end
         m_k++;
      end
      e_busy = m_active;
   endtask

   task automatic cycle(input logic s, input logic v, input logic [DW-1:0] p);
      start     = s;
      pix_valid = v;
      pix_in    = p;
      @(posedge clk);
      model_step(s, v, p);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      start     = 1'b0;
      pix_valid = 1'b0;
      @(posedge clk);
      m_active = 1'b0;
      e_valid  = 1'b0;
      e_done   = 1'b0;
      e_busy   = 1'b0;
      e_tl = '0; e_tr = '0; e_bl = '0; e_br = '0;
      @(negedge clk);
      check_outputs();
      rst = 1'b0;
   endtask

   // gap_mode: 0 = back-to-back, 1 = valid toggles 1-0, 2 = random idle gaps.
   task automatic run_frame(input int gap_mode);
      win_seen = 0;
      cycle(1'b1, 1'b0, '0);
      for (int i = 0; i < int'(NPIX); i++) begin
         if (gap_mode == 2) begin
            repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, DW'($urandom));
         end
         cycle(1'b0, 1'b1, stim[i]);
         if (gap_mode == 1) cycle(1'b0, 1'b0, DW'($urandom));
      end
      cycle(1'b0, 1'b0, '0);
      check("win_count", 32'(win_seen), 32'((W / 2) * (H / 2)));
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      win_seen = 0;
      rst = 1'b1;
      start = 1'b0; pix_valid = 1'b0; pix_in = '0;
      start6 = 1'b0; pix_valid6 = 1'b0; pix_in6 = '0;
      @(negedge clk);
      do_reset();

      // pix_valid while IDLE must not produce anything.
      repeat (3) cycle(1'b0, 1'b1, DW'($urandom));

      for (int i = 0; i < int'(NPIX); i++) stim[i] = DW'(i);
      run_frame(0);
      run_frame(1);

      for (int i = 0; i < int'(NPIX); i++) stim[i] = (i % 2 == 0) ? DW'(31) : DW'(0);
      run_frame(0);

      // Abort after pixel 6, then a clean frame 16..31.
      cycle(1'b1, 1'b0, '0);
      for (int i = 0; i <= 6; i++) cycle(1'b0, 1'b1, DW'(i));
      do_reset();
      repeat (2) cycle(1'b0, 1'b0, '0);
      for (int i = 0; i < int'(NPIX); i++) stim[i] = DW'(16 + i);
      run_frame(0);

      // start mid-frame and with the last pixel is ignored.
      win_seen = 0;
      cycle(1'b1, 1'b0, '0);
      for (int i = 0; i < int'(NPIX); i++) begin
         cycle((i == 3 || i == 9 || i == 15), 1'b1, DW'($urandom));
      end
      repeat (4) cycle(1'b0, 1'b1, DW'($urandom));
      check("win_count_midstart", 32'(win_seen), 32'(4));

      repeat (3) begin
         for (int i = 0; i < int'(NPIX); i++) stim[i] = DW'($urandom);
         run_frame(2);
      end

      // 6x2 instance: pixel value equals raster index.
      win_seen = 0;
      start6 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start6 = 1'b0;
      check("busy6_start", 32'(busy6), 32'(1));
      for (int k = 0; k < int'(W6 * H6); k++) begin
         int r6, c6;
         logic ev;
         pix_valid6 = 1'b1;
         pix_in6    = DW'(k);
         @(posedge clk);
         @(negedge clk);
         r6 = k / W6;
         c6 = k % W6;
         ev = (r6 == 1) && (c6 % 2 == 1);
         check("win_valid6", 32'(win_valid6), 32'(ev));
         check("frame_done6", 32'(frame_done6), 32'(k == int'(W6 * H6) - 1));
         if (ev) begin
            win_seen++;
            check("win_tl6", 32'(win_tl6), 32'(k - 7));
            check("win_tr6", 32'(win_tr6), 32'(k - 6));
            check("win_bl6", 32'(win_bl6), 32'(k - 1));
            check("win_br6", 32'(win_br6), 32'(k));
         end
      end
      pix_valid6 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("busy6_end", 32'(busy6), 32'(0));
      check("win_valid6_end", 32'(win_valid6), 32'(0));
      check("win_count6", 32'(win_seen), 32'(3));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
